// File: rtl/heap_op_sched.sv
// heap_op_sched: arbitrates the single heap input port between a buffered insert stream and queries,
// with a minimum issue gap and a query drain hold-off. Issue counters exist only with HEAP_SCHED_STATS_EN.
module heap_op_sched #(
  parameter int CNT_SIZE    = 20,
  parameter int ADDR_SIZE   = 28,
  parameter int TOTAL_LEVEL = 6,
  parameter int FIFO_DEPTH  = 8,
  parameter int ISSUE_GAP   = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [CNT_SIZE-1:0]  ins_cnt,
  input  logic [ADDR_SIZE-1:0] ins_addr,
  input  logic                 qry_valid,
  output logic                 qry_ready,
  output logic                 qry_done,
  output logic                 heap_valid,
  output logic [CNT_SIZE-1:0]  heap_cnt,
  output logic [ADDR_SIZE-1:0] heap_addr,
  output logic                 heap_query,
  output logic                 busy,
  output logic [31:0]          ins_issued,
  output logic [31:0]          qry_issued
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TOTAL_LEVEL + ISSUE_GAP + 2);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int EW = CNT_SIZE + ADDR_SIZE;
  localparam logic [TW-1:0] GAP_LAST   = TW'(ISSUE_GAP - 2);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(TOTAL_LEVEL + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GAP, QDRAIN} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic          ins_win, grant_ins, grant_bypass, grant_qry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  // An insert arriving at an idle, empty scheduler bypasses the FIFO to keep single-cycle latency.
  assign push = ins_valid && !full && !grant_bypass;
  assign pop  = grant_ins;

  assign ins_ready = !full;
  assign qry_ready = grant_qry && !rst;
  assign qry_done  = (state == QDRAIN) && (tmr == DRAIN_LAST) && !rst;
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    state_nxt    = state;
    tmr_nxt      = tmr;
    starve_nxt   = starve_cnt;
    grant_ins    = 1'b0;
    grant_bypass = 1'b0;
    grant_qry    = 1'b0;
    ins_win      = !empty && (!qry_valid || (starve_cnt == STARVE_TOP));
    unique case (state)
      IDLE: begin
        tmr_nxt = '0;
        if (ins_win)        grant_ins    = 1'b1;
        else if (qry_valid) grant_qry    = 1'b1;
        else if (ins_valid) grant_bypass = 1'b1;
        if (grant_ins || grant_bypass) begin
          starve_nxt = '0;
          if (ISSUE_GAP > 1) state_nxt = GAP;
        end else if (grant_qry) begin
          state_nxt = QDRAIN;
          if (!empty && (starve_cnt != STARVE_TOP)) starve_nxt = starve_cnt + SW'(1);
        end
      end
      GAP: begin
        if (tmr == GAP_LAST) state_nxt = IDLE;
        else                 tmr_nxt   = tmr + TW'(1);
      end
      QDRAIN: begin
        if (tmr == DRAIN_LAST) state_nxt = IDLE;
        else                   tmr_nxt   = tmr + TW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr[PW-1:0]] <= {ins_cnt, ins_addr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      heap_valid <= 1'b0;
      heap_query <= 1'b0;
      heap_cnt   <= '0;
      heap_addr  <= '0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      starve_cnt <= starve_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      heap_valid <= grant_ins || grant_bypass || grant_qry;
      heap_query <= grant_qry;
      // Query ops and idle cycles drive zero payload.
      if (grant_ins) begin
        heap_cnt  <= head[EW-1:ADDR_SIZE];
        heap_addr <= head[ADDR_SIZE-1:0];
      end else if (grant_bypass) begin
        heap_cnt  <= ins_cnt;
        heap_addr <= ins_addr;
      end else begin
        heap_cnt  <= '0;
        heap_addr <= '0;
      end
    end
  end

`ifdef HEAP_SCHED_STATS_EN
  logic [31:0] ins_stat, qry_stat;

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_stat <= '0;
      qry_stat <= '0;
    end else begin
      if (grant_ins || grant_bypass) ins_stat <= ins_stat + 32'd1;
      if (grant_qry)                 qry_stat <= qry_stat + 32'd1;
    end
  end

  assign ins_issued = ins_stat;
  assign qry_issued = qry_stat;
`else
  assign ins_issued = '0;
  assign qry_issued = '0;
`endif

endmodule

// File: tb/tb_heap_op_sched.sv
// Randomized bench for heap_op_sched against a queue-based scheduling model keyed on cycle numbers.
module tb_heap_op_sched;
  localparam int CS = 20, AS = 28, TL = 6, FD = 8, IG = 2, SM = 4;

  logic          clk = 1'b0;
  logic          rst, ins_valid, qry_valid;
  logic [CS-1:0] ins_cnt;
  logic [AS-1:0] ins_addr;
  logic          ins_ready, qry_ready, qry_done, heap_valid, heap_query, busy;
  logic [CS-1:0] heap_cnt;
  logic [AS-1:0] heap_addr;
  logic [31:0]   ins_issued, qry_issued;

  always #5 clk = ~clk;

  heap_op_sched #(.CNT_SIZE(CS), .ADDR_SIZE(AS), .TOTAL_LEVEL(TL), .FIFO_DEPTH(FD),
                  .ISSUE_GAP(IG), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_cnt(ins_cnt), .ins_addr(ins_addr), .qry_valid(qry_valid), .qry_ready(qry_ready),
    .qry_done(qry_done), .heap_valid(heap_valid), .heap_cnt(heap_cnt), .heap_addr(heap_addr),
    .heap_query(heap_query), .busy(busy), .ins_issued(ins_issued), .qry_issued(qry_issued)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: a queue of pending inserts plus the cycle numbers at which the port frees up.
  typedef struct packed { logic [CS-1:0] c; logic [AS-1:0] a; } ent_t;
  ent_t          mq[$];
  int            cyc = 0, next_grant = 0, done_at = -1, starve = 0;
  bit            model_ok = 0;
  logic          m_hv = 0, m_hq = 0;
  logic [CS-1:0] m_hc = '0;
  logic [AS-1:0] m_ha = '0;
  int unsigned   m_ins_st = 0, m_qry_st = 0;

  function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef HEAP_SCHED_STATS_EN
    return v;
`else
    return (v == v + 1) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic step(input bit r, input bit iv, input logic [CS-1:0] ic, input logic [AS-1:0] ia,
                      input bit qv, output bit acc, output bit qg);
    bit   idle, ins_win, g_q, g_b, g_p, e_qd, e_busy, e_ir;
    ent_t e;
    rst = r; ins_valid = iv; ins_cnt = ic; ins_addr = ia; qry_valid = qv;
    @(negedge clk);
    idle    = (cyc >= next_grant);
    ins_win = (mq.size() > 0) && (!qv || starve == SM);
    g_p     = !r && idle && ins_win;
    g_q     = !r && idle && qv && !ins_win;
    g_b     = !r && idle && !ins_win && !qv && iv;
    e_qd    = !r && (cyc == done_at);
    e_busy  = (cyc < next_grant) || (mq.size() > 0);
    e_ir    = (mq.size() < FD);
    if (model_ok) begin
      check("ins_ready", ins_ready, e_ir);
      check("qry_ready", qry_ready, g_q);
      check("qry_done", qry_done, e_qd);
      check("busy", busy, e_busy);
      check("heap_valid", heap_valid, m_hv);
      check("heap_query", heap_query, m_hq);
      check("heap_cnt", heap_cnt, m_hc);
      check("heap_addr", heap_addr, m_ha);
      check("ins_issued", ins_issued, stat_exp(m_ins_st));
      check("qry_issued", qry_issued, stat_exp(m_qry_st));
    end
    acc = !r && iv && e_ir;
    qg  = g_q;
    if (r) begin
      mq.delete();
      next_grant = cyc + 1; done_at = -1; starve = 0;
      m_hv = 0; m_hq = 0; m_hc = '0; m_ha = '0;
      m_ins_st = 0; m_qry_st = 0;
      model_ok = 1;
    end else begin
      m_hv = 0; m_hq = 0; m_hc = '0; m_ha = '0;
      if (g_p) begin
        e = mq.pop_front();
        m_hv = 1; m_hc = e.c; m_ha = e.a;
        starve = 0; next_grant = cyc + IG; m_ins_st++;
      end else if (g_b) begin
        m_hv = 1; m_hc = ic; m_ha = ia;
        starve = 0; next_grant = cyc + IG; m_ins_st++;
      end else if (g_q) begin
        m_hv = 1; m_hq = 1;
        if (mq.size() > 0 && starve < SM) starve++;
        next_grant = cyc + TL + 3; done_at = cyc + TL + 2; m_qry_st++;
      end
      if (iv && e_ir && !g_b) begin
        e.c = ic; e.a = ia;
        mq.push_back(e);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle_n(input int n);
    bit a, q;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, a, q);
  endtask

  initial begin
    bit            a, q, qpend;
    int            k, grants;
    logic [CS-1:0] rc;
    logic [AS-1:0] ra;
    rst = 1; ins_valid = 0; qry_valid = 0; ins_cnt = '0; ins_addr = '0;

    step(1, 0, '0, '0, 0, a, q);
    step(1, 0, '0, '0, 0, a, q);
    idle_n(2);

    // Single insert into an idle block.
    step(0, 1, 20'h00005, 28'h0000ABC, 0, a, q);
    idle_n(4);

    // Query while idle, then fill the FIFO during the drain.
    step(0, 0, '0, '0, 1, a, q);
    check("qry_first_grant", q, 1'b1);
    k = 0;
    for (int t = 0; t < 40 && k < FD; t++) begin
      step(0, 1, CS'(k + 16'h100), AS'(k + 16'h200), 0, a, q);
      if (a) k++;
    end
    check("burst_accepted", k, FD);
    step(0, 1, 20'hDEAD, 28'hBEEF, 0, a, q);
    idle_n(30);

    // Starvation: query held high while one insert is queued.
    grants = 0;
    step(0, 1, 20'h77, 28'h77, 1, a, q);
    if (q) grants++;
    for (int t = 0; t < 60; t++) begin
      step(0, 0, '0, '0, 1, a, q);
      if (q) grants++;
    end
    check("starve_grants", grants >= SM, 1'b1);
    idle_n(12);

    // Reset mid-QDRAIN with inserts queued.
    step(0, 0, '0, '0, 1, a, q);
    for (int i = 0; i < 3; i++) step(0, 1, CS'(i + 1), AS'(i + 9), 0, a, q);
    step(1, 0, '0, '0, 0, a, q);
    idle_n(10);
    step(0, 1, 20'h12345, 28'h1234567, 0, a, q);
    idle_n(4);

    // Random traffic.
    qpend = 0;
    for (int t = 0; t < 3000; t++) begin
      if (!qpend) qpend = ($urandom_range(0, 3) == 0);
      rc = CS'($urandom);
      ra = AS'($urandom);
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1), rc, ra, qpend, a, q);
      if (q || rst) qpend = 0;
    end
    idle_n(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
